alu_req_ctrl: RTL and testbench
===============================

ALU_REQ_CTRL -- requirements
Module: alu_req_ctrl

Interface
REQ-001 Parameter ALU_LAT, default 1: clock edges from operand drive to valid ALU result (range 1..7) SHALL set the capture point.
REQ-002 Parameter TAG_W, default 4: width of the request/response tag.
REQ-003 Port clk  in  1: single clock; all state SHALL change on its rising edge.
REQ-004 Port rst  in  1: reset, asynchronous and active-low.
REQ-005 Ports req_valid in 1, req_ready out 1, req_opcode in 4, req_a in 64, req_b in 64, req_tag in TAG_W: operation request channel.
REQ-006 Ports alu_a out 64, alu_b out 64, alu_opcode out 4: registered operands and opcode driving the ALU.
REQ-007 Ports alu_z in 64, alu_carry in 1, alu_overflow in 1: ALU result inputs.
REQ-008 Ports rsp_valid out 1, rsp_ready in 1, rsp_z out 64, rsp_carry out 1, rsp_overflow out 1, rsp_err out 1, rsp_tag out TAG_W: response channel.
REQ-009 Ports busy out 1, stat_ops out 32, stat_errs out 32: status.

Function
REQ-010 FSM SHALL have states IDLE, ISSUE, RESP; req_ready SHALL be 1 only in IDLE; busy SHALL be 1 outside IDLE.
REQ-011 Request accepted on an edge with req_valid=1 and req_ready=1; inputs sampled only at that edge.
REQ-012 Legal opcodes: 0000,0001,0010,0100,0101,1000-1111; 0011,0110,0111 illegal.
REQ-013 Legal accept: alu_a/alu_b/alu_opcode/tag loaded at accept edge, FSM -> ISSUE, latency counter loaded with ALU_LAT.
REQ-014 ISSUE: counter decrements each edge; on the edge where it reaches 0 (ALU_LAT+1 edges after accept) alu_z/carry/overflow SHALL be captured into rsp_* with rsp_err=0 and FSM -> RESP.
REQ-015 Illegal accept: ALU outputs unchanged, FSM -> RESP at the accept edge with rsp_z=0, rsp_carry=0, rsp_overflow=0, rsp_err=1.
REQ-016 RESP: rsp_valid=1; all rsp_* SHALL hold stable until an edge with rsp_ready=1, then FSM -> IDLE and rsp_valid=0.
REQ-017 alu_a/alu_b/alu_opcode SHALL hold their last issued values while idle.
REQ-018 Only one operation outstanding; req_valid while not IDLE SHALL be ignored (no accept, no state change).
REQ-019 rsp_ready in states other than RESP SHALL have no effect.

Reset
REQ-020 rst=0 SHALL immediately (asynchronously) force IDLE, clear counter, and zero every output register: alu_*, rsp_*, rsp_valid, busy, stat_*; req_ready=1 after release.
REQ-021 Reset mid-ISSUE or mid-RESP SHALL discard the operation with no response emitted.

Configuration
REQ-022 Macro ALU_REQ_STATS_EN defined: stat_ops counts completed legal responses, stat_errs completed illegal responses (counted at the rsp handshake edge), both saturating at 0xFFFFFFFF.
REQ-023 Macro undefined: stat_ops and stat_errs SHALL be constant 0 with no counter logic; ports remain.

Structure
REQ-024 Shared package SHALL hold opcode constants (OP_AND=0000, OP_OR=0001, OP_XNOR=0010, OP_SHL=0100, OP_SHR=0101, OP_ADD=1000, OP_SUB=1001, OP_LT..OP_NE=1010..1111), FSM state encoding, and the opcode-legality function.
REQ-025 One sub-module alu_req_stats SHALL implement the saturating counters, instantiated only under ALU_REQ_STATS_EN.

Verification (bench pairs block with ALU64bit, ALU_LAT=1)
REQ-026 ADD A=0x4000000000000000 B=0x4000000000000000 tag=3 -> rsp_valid 2 cycles after accept, rsp_z=0x8000000000000000, overflow=1, carry=0, tag=3.
REQ-027 SUB A=0x23456789ABCDEF01 B=0x3456789ABCDEF012 -> rsp_z=0xEEEEEEEEEEEEFEEF, rsp_err=0.
REQ-028 opcode 0011 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_z=0, alu_opcode unchanged.
REQ-029 Backpressure: rsp_ready=0 for 5 cycles with req_valid=1 throughout -> rsp_* stable, req_ready=0, no second accept until handshake.
REQ-030 rst=0 asserted one cycle after accept -> all outputs 0 immediately, no response after release; with ALU_REQ_STATS_EN, 3 legal + 1 illegal completed ops -> stat_ops=3, stat_errs=1.

Source files
------------

// File: rtl/alu_req_ctrl_pkg.sv
// Shared definitions for alu_req_ctrl: opcode encodings, FSM state encoding,
// latency counter width and the opcode-legality check.
package alu_req_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XNOR = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_LT   = 4'b1010;
  localparam logic [3:0] OP_LTU  = 4'b1011;
  localparam logic [3:0] OP_GE   = 4'b1100;
  localparam logic [3:0] OP_GEU  = 4'b1101;
  localparam logic [3:0] OP_EQ   = 4'b1110;
  localparam logic [3:0] OP_NE   = 4'b1111;

  // Wide enough for the largest supported ALU latency (7).
  localparam int CNT_W = 3;

  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_XNOR, OP_SHL, OP_SHR,
      OP_ADD, OP_SUB, OP_LT, OP_LTU, OP_GE, OP_GEU, OP_EQ, OP_NE: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_req_stats.sv
// Saturating completion counters for alu_req_ctrl (legal ops and error ops).
module alu_req_stats
  import alu_req_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_ops_i,
  input  logic        inc_errs_i,
  output logic [31:0] stat_ops_o,
  output logic [31:0] stat_errs_o
);

  logic [31:0] ops_q, ops_d;
  logic [31:0] errs_q, errs_d;

  always_comb begin
    ops_d  = ops_q;
    errs_d = errs_q;
    if (inc_ops_i && (ops_q != 32'hFFFF_FFFF)) ops_d = ops_q + 32'd1;
    if (inc_errs_i && (errs_q != 32'hFFFF_FFFF)) errs_d = errs_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops_q  <= '0;
      errs_q <= '0;
    end else begin
      ops_q  <= ops_d;
      errs_q <= errs_d;
    end
  end

  assign stat_ops_o  = ops_q;
  assign stat_errs_o = errs_q;

endmodule

// File: rtl/alu_req_ctrl.sv
// Single-outstanding request controller around a fixed-latency 64-bit ALU.
// Optional completion statistics are built when ALU_REQ_STATS_EN is defined.
module alu_req_ctrl
  import alu_req_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [63:0]      req_a,
  input  logic [63:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [63:0]      alu_z,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_z,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_errs,
  output state_e           dbg_state
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [63:0]        rsp_z_q, rsp_z_d;
  logic               rsp_c_q, rsp_c_d, rsp_o_q, rsp_o_d, rsp_err_q, rsp_err_d;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the sender holds its payload stable while valid is 1 and ready is 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    tag_d     = tag_q;
    rsp_z_d   = rsp_z_q;
    rsp_c_d   = rsp_c_q;
    rsp_o_d   = rsp_o_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          tag_d = req_tag;
          if (op_is_legal(req_opcode)) begin
            alu_a_d  = req_a;
            alu_b_d  = req_b;
            alu_op_d = req_opcode;
            cnt_d    = CNT_W'(ALU_LAT);
            state_d  = ST_ISSUE;
          end else begin
            // Illegal ops never reach the ALU; answer with an error at once.
            rsp_z_d   = '0;
            rsp_c_d   = 1'b0;
            rsp_o_d   = 1'b0;
            rsp_err_d = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        if (cnt_q == '0) begin
          rsp_z_d   = alu_z;
          rsp_c_d   = alu_carry;
          rsp_o_d   = alu_overflow;
          rsp_err_d = 1'b0;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      tag_q     <= '0;
      rsp_z_q   <= '0;
      rsp_c_q   <= 1'b0;
      rsp_o_q   <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      tag_q     <= tag_d;
      rsp_z_q   <= rsp_z_d;
      rsp_c_q   <= rsp_c_d;
      rsp_o_q   <= rsp_o_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign rsp_z        = rsp_z_q;
  assign rsp_carry    = rsp_c_q;
  assign rsp_overflow = rsp_o_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_tag      = tag_q;
  assign dbg_state    = state_q;

`ifdef ALU_REQ_STATS_EN
  logic rsp_hs;
  assign rsp_hs = (state_q == ST_RESP) && rsp_ready;

  alu_req_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .inc_ops_i   (rsp_hs && !rsp_err_q),
    .inc_errs_i  (rsp_hs && rsp_err_q),
    .stat_ops_o  (stat_ops),
    .stat_errs_o (stat_errs)
  );
`else
  assign stat_ops  = '0;
  assign stat_errs = '0;
`endif

endmodule

// File: tb/tb_alu_req_ctrl.sv
// Scoreboard bench for alu_req_ctrl paired with a one-cycle-latency ALU model.
module tb_alu_req_ctrl;
  import alu_req_ctrl_pkg::*;

  localparam int LAT   = 1;
  localparam int TAG_W = 4;
  localparam int RW    = 64 + 3 + TAG_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0, req_ready;
  logic [3:0]       req_opcode = '0;
  logic [63:0]      req_a = '0, req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [63:0]      alu_a, alu_b, alu_z;
  logic [3:0]       alu_opcode;
  logic             alu_carry, alu_overflow;
  logic             rsp_valid, rsp_ready = 1'b0;
  logic [63:0]      rsp_z;
  logic             rsp_carry, rsp_overflow, rsp_err;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [31:0]      stat_ops, stat_errs;
  state_e           dbg_state;

  alu_req_ctrl #(.ALU_LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_z(alu_z), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_err(rsp_err),
    .rsp_tag(rsp_tag), .busy(busy), .stat_ops(stat_ops), .stat_errs(stat_errs),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- ALU partner and reference arithmetic ----------------
  function automatic logic [65:0] alu_fn(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] s;
    logic [63:0] z;
    logic        c, o;
    s = '0; z = '0; c = 1'b0; o = 1'b0;
    case (op)
      4'd0:  z = a & b;
      4'd1:  z = a | b;
      4'd2:  z = ~(a ^ b);
      4'd4:  z = a << b[5:0];
      4'd5:  z = a >> b[5:0];
      4'd8:  begin s = {1'b0, a} + {1'b0, b}; z = s[63:0]; c = s[64]; o = (a[63] == b[63]) && (z[63] != a[63]); end
      4'd9:  begin s = {1'b0, a} - {1'b0, b}; z = s[63:0]; c = s[64]; o = (a[63] != b[63]) && (z[63] != a[63]); end
      4'd10: z = {63'd0, $signed(a) < $signed(b)};
      4'd11: z = {63'd0, a < b};
      4'd12: z = {63'd0, $signed(a) >= $signed(b)};
      4'd13: z = {63'd0, a >= b};
      4'd14: z = {63'd0, a == b};
      4'd15: z = {63'd0, a != b};
      default: z = '0;
    endcase
    return {c, o, z};
  endfunction

  always @(posedge clk) {alu_carry, alu_overflow, alu_z} <= alu_fn(alu_opcode, alu_a, alu_b);

  function automatic logic legal_ref(input logic [3:0] op);
    return !(op inside {4'd3, 4'd6, 4'd7});
  endfunction

  function automatic logic [RW-1:0] model_rsp(input logic [3:0] op, input logic [63:0] a,
                                              input logic [63:0] b, input logic [TAG_W-1:0] t);
    logic [65:0] r;
    r = alu_fn(op, a, b);
    if (legal_ref(op)) return {r[63:0], r[65], r[64], 1'b0, t};
    return {64'd0, 1'b0, 1'b0, 1'b1, t};
  endfunction

  // ---------------- reference model state ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] d_exp;
  int            checks = 0, failures = 0;
  int            cyc = 0, n0 = 0, mlat = 0;
  bit            m_busy = 0, m_valid = 0, m_acc = 0, m_cur_err = 0, mon_en = 0;
  logic [63:0]   m_a = '0, m_b = '0;
  logic [3:0]    m_op = '0;
  logic [31:0]   m_ops = '0, m_errs = '0;
  bit            prev_hold = 0;
  logic [RW-1:0] prev_act;

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [TAG_W-1:0] t, input logic rr, input logic use_lit, input logic [RW-1:0] lit);
    req_valid  = v;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_tag    = t;
    rsp_ready  = rr;
    d_exp      = use_lit ? lit : model_rsp(op, a, b, t);
    @(posedge clk);
    #1;
    cyc++;
    m_acc = 0;
    if (m_busy && m_valid && rsp_ready) begin
      m_busy = 0;
      if (m_cur_err) begin if (m_errs != 32'hFFFF_FFFF) m_errs++; end
      else begin if (m_ops != 32'hFFFF_FFFF) m_ops++; end
    end else if (!m_busy && req_valid) begin
      m_busy    = 1;
      m_acc     = 1;
      n0        = cyc;
      m_cur_err = !legal_ref(req_opcode);
      mlat      = m_cur_err ? 0 : LAT + 1;
      if (!m_cur_err) begin m_a = req_a; m_b = req_b; m_op = req_opcode; end
      exp_q.push_back(d_exp);
    end
    m_valid = m_busy && (cyc >= n0 + mlat);
  endtask

  task automatic idle_step(input logic rr);
    step(1'b0, 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom}, '0, rr, 1'b0, '0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] t, input int bp, input logic hold_v,
                        input logic use_lit, input logic [RW-1:0] lit);
    int guard;
    guard = 0;
    do begin
      step(1'b1, op, a, b, t, 1'b0, use_lit, lit);
      guard++;
    end while (!m_acc && guard < 50);
    if (!m_acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout: got no accept want accept of op %h", op);
      return;
    end
    guard = 0;
    while (m_busy && guard < 100) begin
      logic rr;
      logic jv;
      rr = m_valid && (bp == 0);
      if (m_valid && bp > 0) bp--;
      jv = hold_v ? 1'b1 : 1'($urandom_range(0, 1));
      step(jv, 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
           4'($urandom_range(0, 15)), rr, 1'b0, '0);
      guard++;
    end
    if (m_busy) begin
      checks++; failures++;
      $display("FAIL rsp_timeout: got busy want completion of op %h", op);
    end
  endtask

  task automatic check_zero(input string name);
    logic [337:0] act;
    act = {alu_a, alu_b, alu_opcode, rsp_z, rsp_carry, rsp_overflow, rsp_err, rsp_tag,
           rsp_valid, busy, stat_ops, stat_errs};
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL %s: got %h want all zero", name, act);
    end
  endtask

  // Accept an op, advance `extra` edges, then pull reset asynchronously.
  task automatic reset_mid(input logic [3:0] op, input int extra);
    int guard;
    guard = 0;
    do begin
      step(1'b1, op, {$urandom, $urandom}, {$urandom, $urandom}, 4'd9, 1'b0, 1'b0, '0);
      guard++;
    end while (!m_acc && guard < 50);
    repeat (extra) step(1'b1, 4'd8, '1, '1, 4'd1, 1'b0, 1'b0, '0);
    #2;
    mon_en = 0;
    rst    = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    m_busy = 0; m_valid = 0; prev_hold = 0;
    m_a = '0; m_b = '0; m_op = '0; m_ops = '0; m_errs = '0;
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;
    repeat (5) idle_step(1'b1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [RW-1:0] act, e;
      logic [63:0]   exp_stat;
`ifdef ALU_REQ_STATS_EN
      exp_stat = {m_ops, m_errs};
`else
      exp_stat = 64'd0;
`endif
      checks++;
      if ({req_ready, busy, rsp_valid} !== {!m_busy, m_busy, m_valid}) begin
        failures++;
        $display("FAIL ctrl @%0d: got rdy/busy/vld=%b%b%b want %b%b%b", cyc,
                 req_ready, busy, rsp_valid, !m_busy, m_busy, m_valid);
      end
      checks++;
      if ({alu_a, alu_b, alu_opcode} !== {m_a, m_b, m_op}) begin
        failures++;
        $display("FAIL alu_regs @%0d: got %h %h %h want %h %h %h", cyc, alu_a, alu_b, alu_opcode, m_a, m_b, m_op);
      end
      checks++;
      if ({stat_ops, stat_errs} !== exp_stat) begin
        failures++;
        $display("FAIL stats @%0d: got %h want %h", cyc, {stat_ops, stat_errs}, exp_stat);
      end
      if (rsp_valid) begin
        act = {rsp_z, rsp_carry, rsp_overflow, rsp_err, rsp_tag};
        if (prev_hold) begin
          checks++;
          if (act !== prev_act) begin
            failures++;
            $display("FAIL rsp_hold @%0d: got %h want %h", cyc, act, prev_act);
          end
        end
        if (rsp_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected @%0d: got %h want no response", cyc, act);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              failures++;
              $display("FAIL rsp_data @%0d: got %h want %h", cyc, act, e);
            end
          end
          prev_hold = 0;
        end else begin
          prev_hold = 1;
          prev_act  = act;
        end
      end else begin
        prev_hold = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1;

    run_op(OP_ADD, 64'h4000000000000000, 64'h4000000000000000, 4'd3, 0, 1'b0,
           1'b1, {64'h8000000000000000, 1'b0, 1'b1, 1'b0, 4'd3});
    run_op(OP_SUB, 64'h23456789ABCDEF01, 64'h3456789ABCDEF012, 4'd5, 0, 1'b0,
           1'b1, {64'hEEEEEEEEEEEEFEEF, 1'b1, 1'b0, 1'b0, 4'd5});
    run_op(4'b0011, '1, '1, 4'd7, 0, 1'b0, 1'b0, '0);
    run_op(OP_AND, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 4'd2, 5, 1'b1, 1'b0, '0);

    reset_mid(OP_ADD, 1);
    reset_mid(4'b0110, 1);

    run_op(OP_OR,   64'h1, 64'h2, 4'd1, 1, 1'b0, 1'b0, '0);
    run_op(OP_XNOR, 64'hAAAA, 64'h5555, 4'd2, 0, 1'b0, 1'b0, '0);
    run_op(OP_SHL,  64'h1, 64'd63, 4'd3, 2, 1'b0, 1'b0, '0);
    run_op(4'b0111, 64'h9, 64'h9, 4'd4, 0, 1'b0, 1'b0, '0);
    idle_step(1'b1);
    checks++;
`ifdef ALU_REQ_STATS_EN
    if ({stat_ops, stat_errs} !== {32'd3, 32'd1}) begin
`else
    if ({stat_ops, stat_errs} !== {32'd0, 32'd0}) begin
`endif
      failures++;
      $display("FAIL stat_totals: got %0d/%0d", stat_ops, stat_errs);
    end

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  op;
      logic [63:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? 64'h7FFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      b  = ($urandom_range(0, 3) == 0) ? 64'h8000_0000_0000_0001 : {$urandom, $urandom};
      run_op(op, a, b, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b0, '0);
      repeat ($urandom_range(0, 2)) idle_step(1'($urandom_range(0, 1)));
    end

    repeat (3) idle_step(1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d queued want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
